// File: rtl/fluxo_pkg.sv
// Shared defaults, width helper and level type for the puzzle datapath.
package fluxo_pkg;

  localparam int N_BOTOES_PAD   = 8;
  localparam int N_NIVEIS_PAD   = 6;
  localparam int CICLOS_SEG_PAD = 50_000_000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [largura(N_NIVEIS_PAD)-1:0] nivel_t;

endpackage

// File: rtl/fluxo_dados_n_if.sv
// Bundle between the control unit / matrix driver (master) and the datapath (slave).
interface fluxo_dados_n_if #(
  parameter int N_BOTOES  = 8,
  parameter int WN        = 3,
  parameter int W_JOGADAS = 8,
  parameter int W_SEG     = 6
);
  logic                 zeraN;
  logic                 contaN;
  logic                 zeraM;
  logic [N_BOTOES-1:0]  botoes;
  logic                 matriz_concluido;
  logic [N_BOTOES-1:0]  eventos;
  logic [WN-1:0]        nivel;
  logic                 nivel_ultimo;
  logic [W_JOGADAS-1:0] jogadas;
  logic                 jogadas_esgotadas;
  logic [W_SEG-1:0]     segundos;
  logic                 tempo_esgotado;
  logic                 nivel_concluido;
  logic                 db_multiplo;

  modport master (
    output zeraN, contaN, zeraM, botoes, matriz_concluido,
    input  eventos, nivel, nivel_ultimo, jogadas, jogadas_esgotadas,
           segundos, tempo_esgotado, nivel_concluido, db_multiplo
  );

  modport slave (
    input  zeraN, contaN, zeraM, botoes, matriz_concluido,
    output eventos, nivel, nivel_ultimo, jogadas, jogadas_esgotadas,
           segundos, tempo_esgotado, nivel_concluido, db_multiplo
  );
endinterface

// File: rtl/detector_borda_n.sv
// Two-flop synchroniser plus history flop producing a per-bit rising-edge vector.
module detector_borda_n #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               resync,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] borda
);
  logic [LARGURA-1:0] s1, s2, s3;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= entrada;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // On a level start the history absorbs s2, so held buttons never count as new moves.
  assign borda = resync ? '0 : (s2 & ~s3);
endmodule

// File: rtl/fluxo_dados_n.sv
// Game datapath: button edges with multi-press rejection, level/move counters and
// an optional per-level timer built only when FLUXO_DADOS_TEMPORIZADOR_EN is defined.
module fluxo_dados_n
  import fluxo_pkg::*;
#(
  parameter int N_BOTOES       = N_BOTOES_PAD,
  parameter int N_NIVEIS       = N_NIVEIS_PAD,
  parameter int W_JOGADAS      = 8,
  parameter int LIMITE_JOGADAS = 64,
  parameter int CICLOS_SEG     = CICLOS_SEG_PAD,
  parameter int LIMITE_SEG     = 60
) (
  input  logic          clock,
  input  logic          reset_n,
  fluxo_dados_n_if.slave bus
);
  localparam int WN    = largura(N_NIVEIS);
  localparam int W_SEG = largura(LIMITE_SEG + 1);

  logic [N_BOTOES-1:0]  subida;
  logic [N_BOTOES-1:0]  eventos_r;
  logic [WN-1:0]        nivel_r;
  logic [W_JOGADAS-1:0] jogadas_r;
  logic                 db_r;
  logic                 hist_m;
  logic                 concluido_r;
  logic                 inicio;
  logic                 varios;
  logic                 unico;
  logic                 esgotadas;
  logic                 ultimo;
  logic                 aceita;
  logic [W_SEG-1:0]     segundos_r;
  logic                 tempo_fim;

  assign inicio = bus.zeraN | bus.contaN | bus.zeraM;

  detector_borda_n #(.LARGURA(N_BOTOES)) u_detector (
    .clock   (clock),
    .reset_n (reset_n),
    .resync  (inicio),
    .entrada (bus.botoes),
    .borda   (subida)
  );

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign varios    = |(subida & (subida - N_BOTOES'(1)));
  assign unico     = (subida != '0) && !varios;
  assign esgotadas = jogadas_r >= W_JOGADAS'(LIMITE_JOGADAS);
  assign ultimo    = nivel_r == WN'(N_NIVEIS - 1);
  assign aceita    = unico && !esgotadas && !inicio;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      eventos_r   <= '0;
      db_r        <= 1'b0;
      jogadas_r   <= '0;
      nivel_r     <= '0;
      hist_m      <= 1'b0;
      concluido_r <= 1'b0;
    end else begin
      eventos_r <= aceita ? subida : '0;
      db_r      <= varios && !inicio;

      if (inicio)
        jogadas_r <= '0;
      else if (aceita && !(&jogadas_r))
        jogadas_r <= jogadas_r + W_JOGADAS'(1);

      if (bus.zeraN)
        nivel_r <= '0;
      else if (bus.contaN && !ultimo)
        nivel_r <= nivel_r + WN'(1);

      hist_m      <= bus.matriz_concluido;
      concluido_r <= bus.matriz_concluido & ~hist_m;
    end
  end

`ifdef FLUXO_DADOS_TEMPORIZADOR_EN
  localparam int W_PRE = largura(CICLOS_SEG);

  logic [W_PRE-1:0] prescaler;

  assign tempo_fim = segundos_r == W_SEG'(LIMITE_SEG);

  // Both counters freeze once the limit is reached, which also saturates segundos.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescaler  <= '0;
      segundos_r <= '0;
    end else if (inicio) begin
      prescaler  <= '0;
      segundos_r <= '0;
    end else if (!tempo_fim) begin
      if (prescaler == W_PRE'(CICLOS_SEG - 1)) begin
        prescaler  <= '0;
        segundos_r <= segundos_r + W_SEG'(1);
      end else begin
        prescaler <= prescaler + W_PRE'(1);
      end
    end
  end
`else
  logic unused_tempo;
  assign unused_tempo = (CICLOS_SEG > 0);
  assign segundos_r   = '0;
  assign tempo_fim    = 1'b0;
`endif

  assign bus.eventos           = eventos_r;
  assign bus.nivel             = nivel_r;
  assign bus.nivel_ultimo      = ultimo;
  assign bus.jogadas           = jogadas_r;
  assign bus.jogadas_esgotadas = esgotadas;
  assign bus.segundos          = segundos_r;
  assign bus.tempo_esgotado    = tempo_fim;
  assign bus.nivel_concluido   = concluido_r;
  assign bus.db_multiplo       = db_r;
endmodule

// File: tb/tb_fluxo_dados_n.sv
// Directed-vector bench for fluxo_dados_n (timer checks follow FLUXO_DADOS_TEMPORIZADOR_EN).
module tb_fluxo_dados_n;
  localparam int NB   = 8;
  localparam int NN   = 6;
  localparam int WJ   = 8;
  localparam int LIMJ = 3;
  localparam int CS   = 4;
  localparam int LS   = 2;
  localparam int WNT  = 3;
  localparam int WS   = 2;

  logic clock = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  fluxo_dados_n_if #(.N_BOTOES(NB), .WN(WNT), .W_JOGADAS(WJ), .W_SEG(WS)) bus_i ();

  fluxo_dados_n #(
    .N_BOTOES(NB), .N_NIVEIS(NN), .W_JOGADAS(WJ), .LIMITE_JOGADAS(LIMJ),
    .CICLOS_SEG(CS), .LIMITE_SEG(LS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_i.slave)
  );

  typedef struct {
    logic       zn, cn, zm;
    logic [7:0] b;
    logic       m;
    logic [7:0] ev;
    int         niv;
    int         jog;
    logic       db;
    logic       conc;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic zn, cn, zm, input logic [7:0] b, input logic m,
                     input logic [7:0] ev, input int niv, jog, input logic db, conc);
    vec_t v;
    v.zn = zn; v.cn = cn; v.zm = zm; v.b = b; v.m = m;
    v.ev = ev; v.niv = niv; v.jog = jog; v.db = db; v.conc = conc;
    tab.push_back(v);
  endtask

  task automatic chk(input string nome, input int idx, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", nome, idx, got, exp);
    end
  endtask

  task automatic drive(input logic zn, cn, zm, input logic [7:0] b, input logic m);
    bus_i.zeraN = zn; bus_i.contaN = cn; bus_i.zeraM = zm;
    bus_i.botoes = b; bus_i.matriz_concluido = m;
  endtask

  task automatic chk_zero(input int idx);
    chk("zero_eventos", idx, int'(bus_i.eventos), 0);
    chk("zero_nivel", idx, int'(bus_i.nivel), 0);
    chk("zero_ultimo", idx, int'(bus_i.nivel_ultimo), 0);
    chk("zero_jogadas", idx, int'(bus_i.jogadas), 0);
    chk("zero_esgotadas", idx, int'(bus_i.jogadas_esgotadas), 0);
    chk("zero_segundos", idx, int'(bus_i.segundos), 0);
    chk("zero_tempo", idx, int'(bus_i.tempo_esgotado), 0);
    chk("zero_concluido", idx, int'(bus_i.nivel_concluido), 0);
    chk("zero_multiplo", idx, int'(bus_i.db_multiplo), 0);
  endtask

  initial begin
    // Reset with random inputs, then idle
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clock); #1;
      chk_zero(i);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 8'h00, 0);
      @(posedge clock); #1;
      chk_zero(100 + i);
    end

    // Single press, release, repress
    add(0,0,0,8'h04,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h04,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h04,0, 8'h04,0,1,0,0);
    add(0,0,0,8'h04,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h04,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h04,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h04,0, 8'h04,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    // Two buttons rising together
    add(0,0,0,8'h11,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h11,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h11,0, 8'h00,0,2,1,0);
    add(0,0,0,8'h11,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,2,0,0);
    // Third move hits the limit, fourth is ignored
    add(0,0,0,8'h01,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h01,0, 8'h00,0,2,0,0);
    add(0,0,0,8'h00,0, 8'h01,0,3,0,0);
    add(0,0,0,8'h02,0, 8'h00,0,3,0,0);
    add(0,0,0,8'h02,0, 8'h00,0,3,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,3,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,3,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,3,0,0);
    add(0,0,1,8'h00,0, 8'h00,0,0,0,0);
    // Press coinciding with zeraM is discarded, held button stays silent
    add(0,0,0,8'h08,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h08,0, 8'h00,0,0,0,0);
    add(0,0,1,8'h08,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h08,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,0,0,0);
    // One move, then level advance clears it
    add(0,0,0,8'h20,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h20,0, 8'h00,0,0,0,0);
    add(0,0,0,8'h00,0, 8'h20,0,1,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,1,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,1,0,0);
    add(0,1,0,8'h00,0, 8'h00,1,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,2,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,3,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,4,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,5,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,5,0,0,0);
    add(0,1,0,8'h00,0, 8'h00,5,0,0,0);
    add(1,1,0,8'h00,0, 8'h00,0,0,0,0);
    // Level-solved edge, also under zeraM
    add(0,0,0,8'h00,1, 8'h00,0,0,0,1);
    add(0,0,0,8'h00,1, 8'h00,0,0,0,0);
    add(0,0,0,8'h00,0, 8'h00,0,0,0,0);
    add(0,0,1,8'h00,1, 8'h00,0,0,0,1);

    foreach (tab[i]) begin
      drive(tab[i].zn, tab[i].cn, tab[i].zm, tab[i].b, tab[i].m);
      @(posedge clock); #1;
      chk("eventos", i, int'(bus_i.eventos), int'(tab[i].ev));
      chk("nivel", i, int'(bus_i.nivel), tab[i].niv);
      chk("nivel_ultimo", i, int'(bus_i.nivel_ultimo), (tab[i].niv == NN - 1) ? 1 : 0);
      chk("jogadas", i, int'(bus_i.jogadas), tab[i].jog);
      chk("jogadas_esgotadas", i, int'(bus_i.jogadas_esgotadas), (tab[i].jog >= LIMJ) ? 1 : 0);
      chk("db_multiplo", i, int'(bus_i.db_multiplo), int'(tab[i].db));
      chk("nivel_concluido", i, int'(bus_i.nivel_concluido), int'(tab[i].conc));
`ifndef FLUXO_DADOS_TEMPORIZADOR_EN
      chk("segundos_off", i, int'(bus_i.segundos), 0);
      chk("tempo_off", i, int'(bus_i.tempo_esgotado), 0);
`endif
    end

`ifdef FLUXO_DADOS_TEMPORIZADOR_EN
    // Timer from a fresh level start
    drive(0, 0, 1, 8'h00, 0);
    @(posedge clock); #1;
    chk("seg_start", 0, int'(bus_i.segundos), 0);
    drive(0, 0, 0, 8'h00, 0);
    for (int c = 1; c <= 13; c++) begin
      int es;
      es = (c >= 8) ? 2 : (c >= 4) ? 1 : 0;
      @(posedge clock); #1;
      chk("segundos", c, int'(bus_i.segundos), es);
      chk("tempo_esgotado", c, int'(bus_i.tempo_esgotado), (es == LS) ? 1 : 0);
    end
`else
    drive(0, 0, 0, 8'h00, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      chk("segundos_off", c, int'(bus_i.segundos), 0);
      chk("tempo_off", c, int'(bus_i.tempo_esgotado), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
